// File: rtl/axis_ipg_delay_gate.sv
// AXI-Stream inter-packet delay gate.
// Each packet is held at its first beat until a per-packet delay runs out,
// then the whole packet passes through unchanged. The delay is taken from a
// tuser field or from a software-programmed fixed gap. Packet and beat
// counters are kept for the register block.
module axis_ipg_delay_gate #(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int DELAY_WIDTH          = 32,
   parameter int DELAY_LSB            = 32,
   parameter int CNT_WIDTH            = 32
) (
   input  logic                              axi_aclk,
   input  logic                              rst,
   input  logic                              sw_rst,

   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,

   output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast,

   input  logic                              enable,
   input  logic                              delay_mode,
   input  logic [DELAY_WIDTH-1:0]            sw_ipg,

   output logic [CNT_WIDTH-1:0]              pkt_count,
   output logic [CNT_WIDTH-1:0]              beat_count
);

   typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

   state_t                 state, state_next;
   logic [DELAY_WIDTH-1:0] delay_cnt, delay_cnt_next;
   logic [DELAY_WIDTH-1:0] delay_sel;
   logic                   rst_any;
   logic                   m_hs;

   assign rst_any = rst | sw_rst;

   // Payload is a straight wire; only the handshake is gated.
   assign m_axis_tdata = s_axis_tdata;
   assign m_axis_tstrb = s_axis_tstrb;
   assign m_axis_tuser = s_axis_tuser;
   assign m_axis_tlast = s_axis_tlast;

   // Delay source for the packet at the head; only sampled in IDLE.
   assign delay_sel = delay_mode ? sw_ipg : s_axis_tuser[DELAY_LSB +: DELAY_WIDTH];

   assign m_hs = m_axis_tvalid & m_axis_tready;

   // State and delay counter registers.
   always_ff @(posedge axi_aclk) begin
      if (rst_any) begin
         state     <= IDLE;
         delay_cnt <= '0;
      end else begin
         state     <= state_next;
         delay_cnt <= delay_cnt_next;
      end
   end

   // Next state, delay countdown and valid/ready gating. Handshake outputs
   // are forced low while reset is asserted so no beat slips through.
   always_comb begin
      state_next     = state;
      delay_cnt_next = delay_cnt;
      m_axis_tvalid  = 1'b0;
      s_axis_tready  = 1'b0;
      case (state)
         IDLE: begin
            if (s_axis_tvalid && enable) begin
               if (delay_sel == '0) begin
                  state_next = SEND;
               end else begin
                  state_next     = WAIT;
                  delay_cnt_next = delay_sel;
               end
            end
         end
         WAIT: begin
            delay_cnt_next = delay_cnt - DELAY_WIDTH'(1);
            if (delay_cnt == DELAY_WIDTH'(1)) state_next = SEND;
         end
         SEND: begin
            m_axis_tvalid = s_axis_tvalid & ~rst_any;
            s_axis_tready = m_axis_tready & ~rst_any;
            if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Statistics counters, free-running and wrapping.
   always_ff @(posedge axi_aclk) begin
      if (rst_any) begin
         pkt_count  <= '0;
         beat_count <= '0;
      end else if (m_hs) begin
         beat_count <= beat_count + CNT_WIDTH'(1);
         if (s_axis_tlast) pkt_count <= pkt_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_axis_ipg_delay_gate.sv
// Bench for axis_ipg_delay_gate: table of packet vectors plus hand-written
// sequences; a scoreboard queue checks every beat that leaves the gate.
module tb_axis_ipg_delay_gate;

   localparam int DW = 256;
   localparam int UW = 128;
   localparam int BUDGET = 300;
   localparam logic [DW/8-1:0] LAST_STRB = 32'h00FF_FFFF;

   logic            axi_aclk = 1'b0;
   logic            rst, sw_rst;
   logic [DW-1:0]   s_axis_tdata;
   logic [DW/8-1:0] s_axis_tstrb;
   logic [UW-1:0]   s_axis_tuser;
   logic            s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [DW-1:0]   m_axis_tdata;
   logic [DW/8-1:0] m_axis_tstrb;
   logic [UW-1:0]   m_axis_tuser;
   logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic            enable, delay_mode;
   logic [31:0]     sw_ipg;
   logic [31:0]     pkt_count, beat_count;

   typedef struct packed {
      logic [DW-1:0]   data;
      logic [DW/8-1:0] strb;
      logic [UW-1:0]   user;
      logic            last;
   } beat_t;

   typedef struct {
      logic        mode;
      logic        set_ipg;
      logic [31:0] ipg;
      logic        chg_ipg;
      logic [31:0] new_ipg;
      logic [31:0] udly;
      int          nb;
      int          lat;
      logic [15:0] rdy;
      int          gap_at;
      int          gap_len;
      int          en_off;
      int          hold;
   } vec_t;

   beat_t sb[$];
   beat_t mon_e;
   vec_t  vecs[9];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    rdy_idx = 0;
   int    exp_pkt = 0;
   int    exp_beat = 0;

   axis_ipg_delay_gate dut (
      .axi_aclk(axi_aclk), .rst(rst), .sw_rst(sw_rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb),
      .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
      .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .enable(enable), .delay_mode(delay_mode), .sw_ipg(sw_ipg),
      .pkt_count(pkt_count), .beat_count(beat_count)
   );

   always #5 axi_aclk = ~axi_aclk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard: every beat accepted downstream must match the oldest driven beat.
   always @(negedge axi_aclk) begin
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_beat", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("sb_data", m_axis_tdata, mon_e.data);
            chk("sb_strb", m_axis_tstrb, mon_e.strb);
            chk("sb_user", m_axis_tuser, mon_e.user);
            chk("sb_last", m_axis_tlast, mon_e.last);
         end
      end
   end

   task automatic drive_beat(input logic [UW-1:0] user, input logic last, input logic [DW/8-1:0] strb);
      beat_t bt;
      bt.data = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
      bt.strb = strb;
      bt.user = user;
      bt.last = last;
      s_axis_tdata  = bt.data;
      s_axis_tstrb  = bt.strb;
      s_axis_tuser  = bt.user;
      s_axis_tlast  = bt.last;
      s_axis_tvalid = 1'b1;
      sb.push_back(bt);
   endtask

   // Wait (bounded) for the presented beat to be accepted; cyc = cycles waited.
   task automatic wait_hs(input string nm, input logic [15:0] rdy, input int en_off,
                          input bit in_send, output int cyc, output bit hs);
      cyc = 0;
      hs  = 1'b0;
      m_axis_tready = rdy[rdy_idx % 16];
      rdy_idx++;
      while (!hs && cyc < BUDGET) begin
         @(negedge axi_aclk);
         chk({nm, "_rdy_gate"}, s_axis_tready, m_axis_tvalid ? m_axis_tready : 1'b0);
         if (in_send) chk({nm, "_vld_follow"}, m_axis_tvalid, 1);
         if (m_axis_tvalid && m_axis_tready) begin
            hs = 1'b1;
         end else begin
            @(posedge axi_aclk); #1;
            cyc++;
            if (en_off != 0 && cyc == en_off) enable = 1'b0;
            m_axis_tready = rdy[rdy_idx % 16];
            rdy_idx++;
         end
      end
      if (!hs) chk({nm, "_timeout"}, 1, 0);
   endtask

   task automatic send_pkt(input vec_t v, input string nm);
      logic [UW-1:0] user;
      int cyc;
      bit hs;
      user = {$urandom(), $urandom(), v.udly, $urandom()};
      for (int b = 0; b < v.nb; b++) begin
         if (b == v.gap_at && v.gap_len > 0) begin
            s_axis_tvalid = 1'b0;
            for (int g = 0; g < v.gap_len; g++) begin
               @(negedge axi_aclk);
               chk({nm, "_bubble_vld"}, m_axis_tvalid, 0);
               @(posedge axi_aclk); #1;
            end
         end
         drive_beat(user, b == v.nb - 1, (b == v.nb - 1) ? LAST_STRB : '1);
         if (b == 0 && v.hold > 0) begin
            for (int h = 0; h < v.hold; h++) begin
               @(negedge axi_aclk);
               chk({nm, "_hold_rdy"}, s_axis_tready, 0);
               chk({nm, "_hold_vld"}, m_axis_tvalid, 0);
               @(posedge axi_aclk); #1;
            end
            enable = 1'b1;
         end
         wait_hs(nm, v.rdy, (b == 0) ? v.en_off : 0, b > 0, cyc, hs);
         if (b == 0 && v.lat >= 0) chk({nm, "_latency"}, cyc, v.lat);
         if (b == 0 && v.chg_ipg) sw_ipg = v.new_ipg;
         @(posedge axi_aclk); #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;
   endtask

   initial begin
      logic [UW-1:0] user;
      int cyc;
      bit hs;

      //          mode set ipg    chg new    udly   nb lat rdy       gap gl enoff hold
      vecs[0] = '{1'b0, 1'b1, 32'd0, 1'b0, 32'd0,  32'd0,    4, 1,  16'hFFFF, -1, 0, 0, 0};
      vecs[1] = '{1'b0, 1'b1, 32'd0, 1'b0, 32'd0,  32'd10,   2, 11, 16'hFFFF, -1, 0, 0, 0};
      vecs[2] = '{1'b0, 1'b1, 32'd0, 1'b0, 32'd0,  32'd10,   2, 11, 16'hFFFF, -1, 0, 0, 0};
      vecs[3] = '{1'b1, 1'b1, 32'd5, 1'b1, 32'd20, 32'd1000, 3, 6,  16'hFFFF, -1, 0, 0, 0};
      vecs[4] = '{1'b1, 1'b0, 32'd0, 1'b0, 32'd0,  32'd1000, 2, 21, 16'hFFFF, -1, 0, 0, 0};
      vecs[5] = '{1'b0, 1'b1, 32'd0, 1'b0, 32'd0,  32'd3,    6, -1, 16'h9999,  2, 2, 0, 0};
      vecs[6] = '{1'b0, 1'b1, 32'd0, 1'b0, 32'd0,  32'd10,   2, 11, 16'hFFFF, -1, 0, 4, 0};
      vecs[7] = '{1'b0, 1'b1, 32'd0, 1'b0, 32'd0,  32'd2,    2, 3,  16'hFFFF, -1, 0, 0, 5};
      vecs[8] = '{1'b0, 1'b1, 32'd0, 1'b0, 32'd0,  32'd1,    1, 2,  16'hFFFF, -1, 0, 0, 0};

      rst = 1'b1; sw_rst = 1'b0;
      s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
      enable = 1'b1; delay_mode = 1'b0; sw_ipg = '0;

      // Reset: no handshake even with an input beat offered.
      repeat (2) @(posedge axi_aclk);
      #1 s_axis_tvalid = 1'b1;
      @(negedge axi_aclk);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_s_tready", s_axis_tready, 0);
      @(posedge axi_aclk); #1;
      rst = 1'b0; s_axis_tvalid = 1'b0;
      @(negedge axi_aclk);
      chk("rst_pkt_count", pkt_count, 0);
      chk("rst_beat_count", beat_count, 0);
      chk("rst_idle_vld", m_axis_tvalid, 0);
      @(posedge axi_aclk); #1;

      for (int i = 0; i < 9; i++) begin
         delay_mode = vecs[i].mode;
         if (vecs[i].set_ipg) sw_ipg = vecs[i].ipg;
         if (vecs[i].hold == 0) enable = 1'b1;
         send_pkt(vecs[i], $sformatf("vec%0d", i));
         exp_pkt++;
         exp_beat += vecs[i].nb;
         chk($sformatf("vec%0d_pkt_count", i), pkt_count, exp_pkt);
         chk($sformatf("vec%0d_beat_count", i), beat_count, exp_beat);
      end
      chk("sb_drained", sb.size(), 0);

      // Software reset in the middle of a 5-beat packet.
      enable = 1'b1; delay_mode = 1'b0;
      user = {$urandom(), $urandom(), 32'd0, $urandom()};
      for (int b = 0; b < 2; b++) begin
         drive_beat(user, 1'b0, '1);
         wait_hs("swrst_pre", 16'hFFFF, 0, b > 0, cyc, hs);
         if (b == 0) chk("swrst_latency", cyc, 1);
         @(posedge axi_aclk); #1;
      end
      chk("swrst_pre_beats", beat_count, exp_beat + 2);
      drive_beat(user, 1'b0, '1);
      sw_rst = 1'b1;
      @(negedge axi_aclk);
      chk("swrst_gate_vld", m_axis_tvalid, 0);
      chk("swrst_gate_rdy", s_axis_tready, 0);
      @(posedge axi_aclk); #1;
      sw_rst = 1'b0; s_axis_tvalid = 1'b0;
      sb.delete();
      @(negedge axi_aclk);
      chk("swrst_vld", m_axis_tvalid, 0);
      chk("swrst_pkt_count", pkt_count, 0);
      chk("swrst_beat_count", beat_count, 0);
      @(posedge axi_aclk); #1;
      // A fresh zero-delay packet proves the gate is back in IDLE.
      send_pkt('{1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1, 1, 16'hFFFF, -1, 0, 0, 0}, "post_swrst");
      chk("post_swrst_pkt_count", pkt_count, 1);
      chk("post_swrst_beat_count", beat_count, 1);
      chk("post_swrst_sb_drained", sb.size(), 0);

      repeat (2) @(posedge axi_aclk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_ipg_delay_gate.md
Name: axis_ipg_delay_gate

Overview:
- Sits directly downstream of the replay engine's FIFO-to-AXI-Stream stage, on the axi_aclk domain.
- Holds each packet at its first beat until a per-packet inter-packet delay expires, then passes the whole packet through unmodified.
- The delay comes from a tuser field or from a software-programmed fixed gap, which reproduces pcap timing on the 10G port.
- Also keeps packet and beat counters for the register block.

Parameters:
C_S_AXIS_DATA_WIDTH, 256, AXIS data width (both sides)
C_S_AXIS_TUSER_WIDTH, 128, AXIS tuser width
DELAY_WIDTH, 32, width of the delay field and the delay counter
DELAY_LSB, 32, LSB position of the delay field inside tuser
CNT_WIDTH, 32, width of the statistics counters

Ports:
axi_aclk  in  1  clock
rst  in  1  synchronous reset, active-high
sw_rst  in  1  software reset; same effect as rst
s_axis_tdata  in  C_S_AXIS_DATA_WIDTH  input data
s_axis_tstrb  in  C_S_AXIS_DATA_WIDTH/8  input byte strobes
s_axis_tuser  in  C_S_AXIS_TUSER_WIDTH  input sideband, constant across a packet
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  input last beat
m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  output data
m_axis_tstrb  out  C_S_AXIS_DATA_WIDTH/8  output strobes
m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  output sideband
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output last
enable  in  1  gate enable; low holds packets at the packet boundary
delay_mode  in  1  0 = delay from tuser field, 1 = delay from sw_ipg
sw_ipg  in  DELAY_WIDTH  fixed delay in cycles, used when delay_mode=1
pkt_count  out  CNT_WIDTH  packets completed (tlast handshakes)
beat_count  out  CNT_WIDTH  beats transferred

Behaviour:
- Reset (rst or sw_rst): state=IDLE, delay counter=0, pkt_count=0, beat_count=0.
- Reset outputs: m_axis_tvalid=0, s_axis_tready=0.
- Data path is combinational pass-through:
  - m_axis_tdata/tstrb/tuser/tlast always equal the s_axis_* inputs.
  - Only valid and ready are gated.
- States:
  - IDLE:
    - m_axis_tvalid=0, s_axis_tready=0.
    - If s_axis_tvalid && enable: latch D, where D = sw_ipg if delay_mode=1, else s_axis_tuser[DELAY_LSB+DELAY_WIDTH-1:DELAY_LSB].
    - D==0 -> go to SEND; D>0 -> go to WAIT with counter=D.
  - WAIT:
    - m_axis_tvalid=0, s_axis_tready=0.
    - Counter decrements every cycle.
    - When counter==1, go to SEND next cycle.
    - WAIT is not affected by enable or by s_axis_tvalid.
  - SEND:
    - m_axis_tvalid = s_axis_tvalid; s_axis_tready = m_axis_tready.
    - On a handshake with s_axis_tlast=1 -> go to IDLE.
- Timing: if the first beat is seen in IDLE at cycle T0, its earliest handshake is cycle T0+1+D. Back-to-back packets therefore have at least a 1-cycle bubble.
- Delay latching:
  - D is sampled once per packet, in IDLE only.
  - Changes to sw_ipg or delay_mode during WAIT or SEND take effect at the next packet.
- enable deasserted in WAIT or SEND: the current packet completes normally, then the block stays in IDLE until enable=1.
- Counters:
  - beat_count increments on every m_axis handshake.
  - pkt_count increments on every m_axis handshake with tlast=1.
  - Both wrap modulo 2^CNT_WIDTH.
- Back-pressure:
  - m_axis_tready low in SEND stalls the packet with no data loss.
  - s_axis_tvalid low mid-packet produces a bubble; the block stays in SEND.
- Reset mid-packet: the block returns to IDLE immediately. The upstream FIFO is reset by the same rst/sw_rst, so no partial-packet recovery is required.
- Maximum delay: 2^DELAY_WIDTH-1 cycles, with no overflow.

Test Plan:
1. delay_mode=0, tuser delay=0, 4-beat packet (last tstrb=0x00FF...), m_axis_tready=1 -> first handshake at T0+1, 4 consecutive beats, data/tstrb/tuser identical, pkt_count=1, beat_count=4.
2. tuser delay=10, two back-to-back 2-beat packets each with delay 10 -> first beat of each packet handshakes exactly 11 cycles after it is presented in IDLE; pkt_count=2.
3. delay_mode=1, sw_ipg=5, tuser delay=1000 -> 5-cycle gate used; sw_ipg changed to 20 during SEND -> current packet unaffected, next packet waits 20.
4. m_axis_tready toggles 1,0,0,1 during SEND; s_axis_tvalid drops for 2 cycles mid-packet -> no beat dropped or duplicated, order preserved, m_axis_tvalid follows s_axis_tvalid.
5. enable=0 while in WAIT with counter=7 -> packet still sent after the delay; the next packet is held in IDLE (s_axis_tready=0) until enable=1.
6. sw_rst pulse in SEND after beat 2 of 5 -> next cycle IDLE, m_axis_tvalid=0, counters=0.
